// File: rtl/sseg_char_scheduler.sv
// Paces decoded Morse characters onto an 8-digit seven-segment display:
// a small FIFO feeds a shift register of digits with a minimum dwell between shifts.
module sseg_char_scheduler #(
    parameter int         DWELL      = 12500000,
    parameter logic [5:0] BLANK_CODE = 6'h3F,
    parameter int         FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [5:0] in_code,
    output logic       in_ready,
    input  logic       cmd_clear,
    input  logic       cmd_backspace,
    output logic [5:0] disp0,
    output logic [5:0] disp1,
    output logic [5:0] disp2,
    output logic [5:0] disp3,
    output logic [5:0] disp4,
    output logic [5:0] disp5,
    output logic [5:0] disp6,
    output logic [5:0] disp7,
    output logic [3:0] count,
    output logic       busy
);

    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam int                 CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [FIFO_AW:0]   FULL_OCC   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [CW-1:0]      DWELL_LOAD = CW'(DWELL - 1);

    typedef enum logic {IDLE, DWELL_S} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                pend, pend_n;
    logic                do_shift, do_bksp;

    logic [5:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    occ, occ_n;
    logic                fifo_empty, push;

    logic [7:0][5:0]     disp;

    assign fifo_empty = (occ == '0);
    assign push       = in_valid && in_ready && !cmd_clear;
    assign busy       = (state == DWELL_S) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
        end
    end

    // Clear overrides everything; in IDLE a backspace (pending or live) wins over a shift.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pend_n   = pend;
        do_shift = 1'b0;
        do_bksp  = 1'b0;
        if (cmd_clear) begin
            state_n = IDLE;
            cnt_n   = '0;
            pend_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend || cmd_backspace) begin
                        do_bksp = 1'b1;
                        pend_n  = 1'b0;
                    end else if (!fifo_empty) begin
                        do_shift = 1'b1;
                        state_n  = DWELL_S;
                        cnt_n    = DWELL_LOAD;
                    end
                end
                DWELL_S: begin
                    if (cmd_backspace) pend_n = 1'b1;
                    if (cnt == '0) state_n = IDLE;
                    else           cnt_n   = cnt - 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        occ_n = occ;
        if (push && !do_shift)      occ_n = occ + 1'b1;
        else if (!push && do_shift) occ_n = occ - 1'b1;
    end

    // in_ready is registered from next occupancy, so a pop re-opens it one cycle later.
    always_ff @(posedge clk) begin
        if (reset || cmd_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (do_shift) rd_ptr <= rd_ptr + 1'b1;
            occ      <= occ_n;
            in_ready <= (occ_n != FULL_OCC);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_code;
    end

    always_ff @(posedge clk) begin
        if (reset || cmd_clear) begin
            disp  <= {8{BLANK_CODE}};
            count <= '0;
        end else if (do_shift) begin
            disp <= {disp[6:0], mem[rd_ptr]};
            if (count != 4'd8) count <= count + 1'b1;
        end else if (do_bksp && count != '0) begin
            disp  <= {BLANK_CODE, disp[7:1]};
            count <= count - 1'b1;
        end
    end

    assign disp0 = disp[0];
    assign disp1 = disp[1];
    assign disp2 = disp[2];
    assign disp3 = disp[3];
    assign disp4 = disp[4];
    assign disp5 = disp[5];
    assign disp6 = disp[6];
    assign disp7 = disp[7];

endmodule

// File: tb/tb_sseg_char_scheduler.sv
// Directed bench for sseg_char_scheduler with DWELL=4, depth-4 FIFO.
module tb_sseg_char_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [5:0] in_code = '0;
    logic       in_ready;
    logic       cmd_clear = 1'b0;
    logic       cmd_backspace = 1'b0;
    logic [5:0] disp0, disp1, disp2, disp3, disp4, disp5, disp6, disp7;
    logic [3:0] count;
    logic       busy;

    logic [7:0][5:0] dv;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    sseg_char_scheduler #(.DWELL(4), .BLANK_CODE(6'h3F), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
        .in_ready(in_ready), .cmd_clear(cmd_clear), .cmd_backspace(cmd_backspace),
        .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
        .disp4(disp4), .disp5(disp5), .disp6(disp6), .disp7(disp7),
        .count(count), .busy(busy)
    );

    assign dv = {disp7, disp6, disp5, disp4, disp3, disp2, disp1, disp0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; in_valid = 1'b0; cmd_clear = 1'b0; cmd_backspace = 1'b0;
        tick;
        reset = 1'b0;
    endtask

    // Offer c, wait for in_ready, and return the edge number at which it was taken.
    task automatic push_code(input logic [5:0] c, output int acc);
        in_code = c;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !in_ready; i++) tick;
        if (!in_ready) begin
            n_err++;
            $display("FAIL push_timeout code=%0d in_ready never rose", c);
        end
        tick;
        acc = cyc;
    endtask

    task automatic test_reset;
        int a;
        do_reset;
        push_code(6'($urandom_range(0, 63)), a);
        push_code(6'($urandom_range(0, 63)), a);
        push_code(6'($urandom_range(0, 63)), a);
        in_valid = 1'b0;
        cmd_backspace = 1'b1; tick; cmd_backspace = 1'b0;
        reset = 1'b1; in_valid = 1'b1; tick;
        reset = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (dv[k] !== 6'h3F) begin n_err++; $display("FAIL reset_disp%0d got %0h exp 3f", k, dv[k]); end
        end
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", busy); end
        repeat (8) tick;
        n_vec++; if (count !== 4'd0 || busy !== 1'b0)
            begin n_err++; $display("FAIL reset_residual count=%0d busy=%0b exp 0/0", count, busy); end
    endtask

    task automatic test_pacing;
        do_reset;
        in_code = 6'd1; in_valid = 1'b1; tick;                   // edge N
        n_vec++; if (disp0 !== 6'h3F) begin n_err++; $display("FAIL pace_N disp0 got %0h exp 3f", disp0); end
        in_code = 6'd2; tick;                                      // N+1
        n_vec++; if (disp0 !== 6'd1 || count !== 4'd1)
            begin n_err++; $display("FAIL pace_N1 disp0=%0h count=%0d exp 1/1", disp0, count); end
        in_code = 6'd3; tick;                                      // N+2
        in_valid = 1'b0;
        repeat (3) tick;                                           // N+5
        n_vec++; if (disp0 !== 6'd1) begin n_err++; $display("FAIL pace_N5 disp0 got %0h exp 1", disp0); end
        tick;                                                      // N+6
        n_vec++; if (disp0 !== 6'd2 || disp1 !== 6'd1 || count !== 4'd2)
            begin n_err++; $display("FAIL pace_N6 d0=%0h d1=%0h cnt=%0d exp 2/1/2", disp0, disp1, count); end
        repeat (5) tick;                                           // N+11
        n_vec++; if (disp0 !== 6'd3 || disp1 !== 6'd2 || disp2 !== 6'd1 || count !== 4'd3)
            begin n_err++; $display("FAIL pace_N11 d0=%0h d1=%0h d2=%0h cnt=%0d exp 3/2/1/3", disp0, disp1, disp2, count); end
        repeat (3) tick;                                           // N+14
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL pace_busy_N14 got %0b exp 1", busy); end
        tick;                                                      // N+15
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL pace_busy_N15 got %0b exp 0", busy); end
    endtask

    task automatic test_fifo_full;
        int acc [8];
        int e0;
        do_reset;
        for (int c = 1; c <= 7; c++) begin
            push_code(6'(c), acc[c]);
            if (c == 5) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_after_4th got %0b exp 0", in_ready); end
            end
        end
        in_valid = 1'b0;
        e0 = acc[1];
        n_vec++; if (acc[5] - e0 !== 4) begin n_err++; $display("FAIL full_acc5 got E%0d exp E4", acc[5] - e0); end
        n_vec++; if (acc[6] - e0 !== 7) begin n_err++; $display("FAIL full_acc6 got E%0d exp E7", acc[6] - e0); end
        n_vec++; if (acc[7] - e0 !== 12) begin n_err++; $display("FAIL full_acc7 got E%0d exp E12", acc[7] - e0); end
        for (int i = 0; i < 100 && busy; i++) tick;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_drain_timeout busy=%0b exp 0", busy); end
        n_vec++; if (count !== 4'd7) begin n_err++; $display("FAIL full_count got %0d exp 7", count); end
        for (int k = 0; k < 7; k++) begin
            n_vec++;
            if (dv[k] !== 6'(7 - k)) begin n_err++; $display("FAIL full_order disp%0d got %0h exp %0h", k, dv[k], 7 - k); end
        end
        n_vec++; if (disp7 !== 6'h3F) begin n_err++; $display("FAIL full_disp7 got %0h exp 3f", disp7); end
    endtask

    task automatic test_overflow;
        int a;
        do_reset;
        for (int c = 1; c <= 10; c++) push_code(6'(c), a);
        in_valid = 1'b0;
        for (int i = 0; i < 100 && busy; i++) tick;
        n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d exp 8", count); end
        n_vec++; if (disp0 !== 6'd10) begin n_err++; $display("FAIL ovf_disp0 got %0h exp a", disp0); end
        n_vec++; if (disp7 !== 6'd3) begin n_err++; $display("FAIL ovf_disp7 got %0h exp 3", disp7); end
    endtask

    task automatic test_backspace;
        int a;
        do_reset;
        for (int c = 1; c <= 3; c++) push_code(6'(c), a);
        in_valid = 1'b0;
        for (int i = 0; i < 40 && disp0 !== 6'd3; i++) tick;      // edge S: shift of 3
        n_vec++; if (disp0 !== 6'd3) begin n_err++; $display("FAIL bs_setup disp0 got %0h exp 3", disp0); end
        cmd_backspace = 1'b1; tick; cmd_backspace = 1'b0;          // S+1, mid-dwell
        repeat (3) tick;                                           // S+4: back in IDLE
        n_vec++; if (disp0 !== 6'd3 || count !== 4'd3 || busy !== 1'b0)
            begin n_err++; $display("FAIL bs_pending_hold d0=%0h cnt=%0d busy=%0b exp 3/3/0", disp0, count, busy); end
        tick;                                                      // S+5
        n_vec++; if (disp0 !== 6'd2 || disp1 !== 6'd1 || disp2 !== 6'h3F || count !== 4'd2)
            begin n_err++; $display("FAIL bs_first d0=%0h d1=%0h d2=%0h cnt=%0d exp 2/1/3f/2", disp0, disp1, disp2, count); end
        cmd_backspace = 1'b1; tick; cmd_backspace = 1'b0;
        n_vec++; if (disp0 !== 6'd1 || count !== 4'd1)
            begin n_err++; $display("FAIL bs_idle d0=%0h cnt=%0d exp 1/1", disp0, count); end
        tick;
        repeat (2) begin
            cmd_backspace = 1'b1; tick; cmd_backspace = 1'b0; tick;
        end
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL bs_count_floor got %0d exp 0", count); end
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (dv[k] !== 6'h3F) begin n_err++; $display("FAIL bs_blank disp%0d got %0h exp 3f", k, dv[k]); end
        end
    endtask

    task automatic test_clear;
        int a;
        do_reset;
        push_code(6'd11, a);
        push_code(6'd12, a);
        push_code(6'd13, a);                                       // 12,13 queued, in DWELL
        n_vec++; if (busy !== 1'b1 || disp0 !== 6'd11)
            begin n_err++; $display("FAIL clr_setup busy=%0b d0=%0h exp 1/b", busy, disp0); end
        in_code = 6'd14; in_valid = 1'b1; cmd_clear = 1'b1; cmd_backspace = 1'b1;
        tick;
        in_valid = 1'b0; cmd_clear = 1'b0; cmd_backspace = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (dv[k] !== 6'h3F) begin n_err++; $display("FAIL clr_disp%0d got %0h exp 3f", k, dv[k]); end
        end
        n_vec++; if (count !== 4'd0 || busy !== 1'b0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL clr_state cnt=%0d busy=%0b rdy=%0b exp 0/0/1", count, busy, in_ready); end
        repeat (12) tick;
        n_vec++; if (count !== 4'd0 || disp0 !== 6'h3F || busy !== 1'b0)
            begin n_err++; $display("FAIL clr_no_leak cnt=%0d d0=%0h busy=%0b exp 0/3f/0", count, disp0, busy); end
    endtask

    initial begin
        do_reset;
        n_vec++; if (count !== 4'd0 || disp0 !== 6'h3F || in_ready !== 1'b1 || busy !== 1'b0)
            begin n_err++; $display("FAIL por cnt=%0d d0=%0h rdy=%0b busy=%0b", count, disp0, in_ready, busy); end
        test_reset;
        test_pacing;
        test_fifo_full;
        test_overflow;
        test_backspace;
        test_clear;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
